// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg: shared definitions for the piso_tx serial transmitter.
//   state_t  - two-state transmitter FSM encoding (IDLE / SHIFT)
//   clog2_f  - ceiling log2 used to size the bit counter (minimum 1 bit)
package piso_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Ceiling log2; a counter is always at least one bit wide.
  function automatic int clog2_f(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 32'sd1;
    end
    if (result < 32'sd1) begin
      result = 32'sd1;
    end else begin
      result = result;
    end
    return result;
  endfunction

endpackage

// File: rtl/piso_tx_if.sv
// piso_tx_if: handshake and serial-side signals of the piso_tx transmitter.
//   en          - clock enable for the whole link
//   load_valid  - upstream offers load_data
//   load_data   - WIDTH-bit word to transmit
//   load_ready  - transmitter can take a word this cycle
//   sout        - serial data bit
//   sout_valid  - sout carries a data bit
//   busy        - transmitter is shifting a word
//   done        - one-cycle pulse after the last bit of a word
// master: the upstream/driver side; slave: the transmitter.
interface piso_tx_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output en, load_valid, load_data,
    input  load_ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  en, load_valid, load_data,
    output load_ready, sout, sout_valid, busy, done
  );

endinterface

// File: rtl/piso_tx_shift_reg_en.sv
// shift_reg_en: WIDTH-bit loadable shift register with clock enable.
//   clk, reset - clock and asynchronous active-high reset
//   en         - nothing changes while low
//   load       - capture din (has priority over shift)
//   shift      - shift one place toward the end sent first
//   din        - parallel word
//   next_bit   - the bit that goes out after the one currently being sent
// MSB_FIRST=1 shifts left (MSB leaves first), 0 shifts right.
module shift_reg_en #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             next_bit
);

  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] shifted_s;

  // Shifted image of the register in the configured direction.
  always_comb begin
    if (MSB_FIRST) begin
      shifted_s = {data_r[WIDTH-2:0], 1'b0};
    end else begin
      shifted_s = {1'b0, data_r[WIDTH-1:1]};
    end
  end

  // Register update: load wins over shift, everything holds without en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r <= {WIDTH{1'b0}};
    end else if (en && load) begin
      data_r <= din;
    end else if (en && shift) begin
      data_r <= shifted_s;
    end else begin
      data_r <= data_r;
    end
  end

  // The bit currently on the line is the register's outgoing end, so the
  // following one sits right next to it.
  assign next_bit = MSB_FIRST ? data_r[WIDTH-2] : data_r[1];

endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with clock enable.
//   clk, reset - clock and asynchronous active-high reset
//   bus        - piso_tx_if slave: en, load_valid/load_data/load_ready
//                handshake, sout/sout_valid serial output, busy, done
// A word is accepted on an enabled edge with load_valid && load_ready and
// its bits appear on sout one per enabled edge, starting at the accept
// edge. A new word can be accepted while the last bit is on the line so
// consecutive words stream with no gap.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  piso_tx_if.slave   bus
);

  localparam int             CNT_W    = clog2_f(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             sout_r;
  logic             sout_next_s;
  logic             sout_valid_r;
  logic             sout_valid_next_s;
  logic             done_r;
  logic             done_next_s;
  logic             last_s;
  logic             ready_s;
  logic             load_s;
  logic             shift_s;
  logic             first_bit_s;
  logic             next_bit_s;

  shift_reg_en #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .en       (bus.en),
    .load     (load_s),
    .shift    (shift_s),
    .din      (bus.load_data),
    .next_bit (next_bit_s)
  );

  assign last_s      = (state_r == ST_SHIFT) && (count_r == CNT_LAST);
  // Ready ignores en on purpose: upstream sees a stable ready while stalled.
  assign ready_s     = (state_r == ST_IDLE) || last_s;
  assign first_bit_s = MSB_FIRST ? bus.load_data[WIDTH-1] : bus.load_data[0];

  // Next-state and next-output decode for the transmitter FSM.
  always_comb begin
    state_next_s      = state_r;
    count_next_s      = count_r;
    sout_next_s       = sout_r;
    sout_valid_next_s = sout_valid_r;
    done_next_s       = 1'b0;
    load_s            = 1'b0;
    shift_s           = 1'b0;
    if (bus.en) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.load_valid) begin
            load_s            = 1'b1;
            sout_next_s       = first_bit_s;
            sout_valid_next_s = 1'b1;
            count_next_s      = {CNT_W{1'b0}};
            state_next_s      = ST_SHIFT;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (last_s) begin
            done_next_s = 1'b1;
            if (bus.load_valid) begin
              // Back-to-back: next word's first bit follows with no gap.
              load_s            = 1'b1;
              sout_next_s       = first_bit_s;
              sout_valid_next_s = 1'b1;
              count_next_s      = {CNT_W{1'b0}};
              state_next_s      = ST_SHIFT;
            end else begin
              sout_next_s       = 1'b0;
              sout_valid_next_s = 1'b0;
              count_next_s      = {CNT_W{1'b0}};
              state_next_s      = ST_IDLE;
            end
          end else begin
            shift_s      = 1'b1;
            sout_next_s  = next_bit_s;
            count_next_s = count_r + CNT_W'(1'b1);
          end
        end
        default: begin
          state_next_s      = ST_IDLE;
          sout_next_s       = 1'b0;
          sout_valid_next_s = 1'b0;
          count_next_s      = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // State, counter and registered outputs; done is cleared whenever it
  // does not pulse, including stalled edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      count_r      <= {CNT_W{1'b0}};
      sout_r       <= 1'b0;
      sout_valid_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      count_r      <= count_next_s;
      sout_r       <= sout_next_s;
      sout_valid_r <= sout_valid_next_s;
      done_r       <= done_next_s;
    end
  end

  assign bus.load_ready = ready_s;
  assign bus.sout       = sout_r;
  assign bus.sout_valid = sout_valid_r;
  assign bus.busy       = (state_r == ST_SHIFT);
  assign bus.done       = done_r;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: drives an MSB-first and an LSB-first piso_tx with identical
// stimulus. A word-level model (bits left in the current word) predicts
// handshake, busy, sout_valid and done; accepted words push their bits in
// transmit order into per-DUT queues that a separate monitor drains.
module tb_piso_tx;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset_s;
  logic             en_s;
  logic             lv_s;
  logic [WIDTH-1:0] ld_s;

  piso_tx_if #(.WIDTH(WIDTH)) bus_m ();
  piso_tx_if #(.WIDTH(WIDTH)) bus_l ();

  assign bus_m.en         = en_s;
  assign bus_m.load_valid = lv_s;
  assign bus_m.load_data  = ld_s;
  assign bus_l.en         = en_s;
  assign bus_l.load_valid = lv_s;
  assign bus_l.load_data  = ld_s;

  piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .reset (reset_s),
    .bus   (bus_m.slave)
  );

  piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .reset (reset_s),
    .bus   (bus_l.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int left  = 0;      // bits of the current word still to be shown, incl. the one on sout
  bit acc      = 1'b0;
  bit done_exp = 1'b0;
  bit exp_q [2][$];   // [0] MSB-first DUT, [1] LSB-first DUT
  bit last_bit [2];
  bit mon_en;
  bit mon_rst;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t act=%0h exp=%0h", name, d, $time, act, exp);
    end
  endtask

  // Model of one rising edge, in terms of words and bits left.
  task automatic model_edge();
    bit ready;
    ready    = (left <= 1);
    acc      = 1'b0;
    done_exp = 1'b0;
    if (en_s) begin
      if (left == 1) done_exp = 1'b1;
      if (lv_s && ready) begin
        acc  = 1'b1;
        left = WIDTH;
        for (int i = 0; i < WIDTH; i++) begin
          exp_q[0].push_back(ld_s[WIDTH-1-i]);
          exp_q[1].push_back(ld_s[i]);
        end
      end else if (left > 0) begin
        left = left - 1;
      end
    end
  endtask

  task automatic chk_bus(input int d, input logic sv, input logic bz, input logic rdy, input logic dn);
    chk("sout_valid", d, {31'b0, sv},  {31'b0, left > 0});
    chk("busy",       d, {31'b0, bz},  {31'b0, left > 0});
    chk("load_ready", d, {31'b0, rdy}, {31'b0, left <= 1});
    chk("done",       d, {31'b0, dn},  {31'b0, done_exp});
  endtask

  task automatic check_flags();
    chk_bus(0, bus_m.sout_valid, bus_m.busy, bus_m.load_ready, bus_m.done);
    chk_bus(1, bus_l.sout_valid, bus_l.busy, bus_l.load_ready, bus_l.done);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset_s) begin
      model_edge();
    end else begin
      left = 0; acc = 1'b0; done_exp = 1'b0;
    end
    @(negedge clk);
    check_flags();
  endtask

  task automatic send_word(input logic [WIDTH-1:0] data);
    lv_s = 1'b1;
    ld_s = data;
    acc  = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) cycle();
    if (!acc) chk("accept_timeout", 0, 32'd0, 32'd1);
    lv_s = 1'b0;
  endtask

  // Monitor: pops one expected bit per enabled edge while sout_valid,
  // and checks that a stalled line holds its bit.
  always begin
    @(posedge clk);
    mon_en  = en_s;
    mon_rst = reset_s;
    @(negedge clk);
    if (!mon_rst && !reset_s) begin
      for (int d = 0; d < 2; d++) begin
        logic so, sv;
        so = (d == 0) ? bus_m.sout : bus_l.sout;
        sv = (d == 0) ? bus_m.sout_valid : bus_l.sout_valid;
        if (sv) begin
          if (mon_en) begin
            if (exp_q[d].size() == 0) begin
              chk("unexpected_bit", d, 32'd1, 32'd0);
            end else begin
              last_bit[d] = exp_q[d].pop_front();
              chk("sout", d, {31'b0, so}, {31'b0, last_bit[d]});
            end
          end else begin
            chk("stall_hold", d, {31'b0, so}, {31'b0, last_bit[d]});
          end
        end
      end
    end
  end

  initial begin
    reset_s = 1'b1;
    en_s    = 1'b0;
    lv_s    = 1'b0;
    ld_s    = '0;
    #18;
    check_flags();
    chk("sout_rst", 0, {31'b0, bus_m.sout}, 32'd0);
    chk("sout_rst", 1, {31'b0, bus_l.sout}, 32'd0);
    @(negedge clk);
    reset_s = 1'b0;
    en_s    = 1'b1;

    // Single word, then idle long enough to see done and return to idle.
    send_word(8'hA5);
    repeat (10) cycle();

    // Enable stall after bit 2.
    send_word(8'hF0);
    repeat (2) cycle();
    en_s = 1'b0;
    repeat (3) cycle();
    en_s = 1'b1;
    repeat (8) cycle();

    // Back-to-back words.
    send_word(8'h81);
    send_word(8'h7E);
    repeat (10) cycle();

    // Backpressure: word offered mid-stream waits for ready.
    send_word(8'h55);
    repeat (3) cycle();
    send_word(8'h33);
    repeat (10) cycle();

    // Reset in the middle of a word.
    send_word(8'hC3);
    repeat (4) cycle();
    #3;
    reset_s = 1'b1;
    left = 0; done_exp = 1'b0;
    exp_q[0].delete();
    exp_q[1].delete();
    #1;
    check_flags();
    chk("sout_midrst", 0, {31'b0, bus_m.sout}, 32'd0);
    chk("sout_midrst", 1, {31'b0, bus_l.sout}, 32'd0);
    repeat (2) cycle();
    reset_s = 1'b0;
    send_word(8'h01);
    repeat (10) cycle();

    // Randomized traffic with random enable.
    for (int n = 0; n < 400; n++) begin
      en_s = ($urandom_range(3) != 0);
      if (!lv_s || acc) begin
        lv_s = ($urandom_range(2) == 0);
        ld_s = WIDTH'($urandom);
      end
      cycle();
    end

    lv_s = 1'b0;
    en_s = 1'b1;
    repeat (20) cycle();
    chk("queue_drained", 0, exp_q[0].size(), 32'd0);
    chk("queue_drained", 1, exp_q[1].size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
